fetch_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage MIPS pipeline: PC register, next-PC selection, instruction-memory address drive and the IF/ID pipeline register.
- Directly downstream of the hazard/stall unit. Consumes its active-high hold signals `pc_write` and `IF_ID_write`, plus the ID-stage redirect select `s_npc`.
- Feeds the ID stage with the fetched instruction, PC+4 and a valid bit.
- Keeps saturating stall/flush counters for performance debug.

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/npc_gen.sv | 31 +++
 rtl/fetch_stage.sv | 110 +++++++++++
 tb/tb_fetch_stage.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the MIPS pipeline front end: next-PC selects and
// the IF/ID register layout.
package cpu_pkg;

  localparam logic [1:0] NPC_SEQ = 2'b00;
  localparam logic [1:0] NPC_BR  = 2'b01;
  localparam logic [1:0] NPC_J   = 2'b10;
  localparam logic [1:0] NPC_JR  = 2'b11;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
  } if_id_t;

  localparam if_id_t IF_ID_BUBBLE = '{instr: NOP_INSTR, pc4: 32'h0, valid: 1'b0};

endpackage

// File: rtl/npc_gen.sv
// Combinational next-PC mux with branch and jump target arithmetic.
module npc_gen
  import cpu_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic [31:0] id_pc4_i,
  input  logic [1:0]  sel_i,
  input  logic [15:0] br_imm16_i,
  input  logic [25:0] j_index_i,
  input  logic [31:0] jr_target_i,
  output logic [31:0] pc4_o,
  output logic [31:0] npc_o
);

  logic [31:0] br_offset;

  assign pc4_o     = pc_i + 32'd4;
  assign br_offset = {{14{br_imm16_i[15]}}, br_imm16_i, 2'b00};

  always_comb begin
    npc_o = pc4_o;
    unique case (sel_i)
      NPC_SEQ: npc_o = pc4_o;
      NPC_BR:  npc_o = id_pc4_i + br_offset;
      NPC_J:   npc_o = {id_pc4_i[31:28], j_index_i, 2'b00};
      NPC_JR:  npc_o = jr_target_i;
      default: npc_o = pc4_o;
    endcase
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register and
// saturating stall/flush performance counters.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             pc_write_i,
  input  logic             if_id_write_i,
  input  logic [1:0]       s_npc_i,
  input  logic [15:0]      br_imm16_i,
  input  logic [25:0]      j_index_i,
  input  logic [31:0]      jr_target_i,
  output logic [31:0]      imem_addr_o,
  input  logic [31:0]      imem_rdata_i,
  output logic [31:0]      id_instr_o,
  output logic [31:0]      id_pc4_o,
  output logic             id_valid_o,
  output logic             addr_err_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  logic [31:0]      pc_q, pc_d;
  if_id_t           if_id_q, if_id_d;
  logic             addr_err_q, addr_err_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic        redirect;
  logic [1:0]  npc_sel;
  logic [31:0] pc4;
  logic [31:0] npc;

  // A bubble in ID must not steer the PC, so the select is gated by valid.
  assign redirect = (s_npc_i != NPC_SEQ) && if_id_q.valid;
  assign npc_sel  = redirect ? s_npc_i : NPC_SEQ;

  npc_gen u_npc_gen (
    .pc_i        (pc_q),
    .id_pc4_i    (if_id_q.pc4),
    .sel_i       (npc_sel),
    .br_imm16_i  (br_imm16_i),
    .j_index_i   (j_index_i),
    .jr_target_i (jr_target_i),
    .pc4_o       (pc4),
    .npc_o       (npc)
  );

  always_comb begin
    pc_d        = pc_q;
    if_id_d     = if_id_q;
    addr_err_d  = addr_err_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;

    if (!pc_write_i) begin
      pc_d = npc;
      if (npc[1:0] != 2'b00) begin
        addr_err_d = 1'b1;
      end
    end

    if (!if_id_write_i) begin
      if (redirect) begin
        if_id_d = IF_ID_BUBBLE;
      end else begin
        if_id_d = '{instr: imem_rdata_i, pc4: pc4, valid: 1'b1};
      end
    end

    if (pc_write_i && (stall_cnt_q != CntMax)) begin
      stall_cnt_d = stall_cnt_q + CntOne;
    end
    if (redirect && !pc_write_i && (flush_cnt_q != CntMax)) begin
      flush_cnt_d = flush_cnt_q + CntOne;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q        <= RESET_PC;
      if_id_q     <= IF_ID_BUBBLE;
      addr_err_q  <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      pc_q        <= pc_d;
      if_id_q     <= if_id_d;
      addr_err_q  <= addr_err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign imem_addr_o = pc_q;
  assign id_instr_o  = if_id_q.instr;
  assign id_pc4_o    = if_id_q.pc4;
  assign id_valid_o  = if_id_q.valid;
  assign addr_err_o  = addr_err_q;
  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed vector bench for fetch_stage with a PC-indexed instruction memory model.
module tb_fetch_stage;

  localparam int unsigned CntW = 4;

  logic            clk;
  logic            rst_n;
  logic            pc_write;
  logic            if_id_write;
  logic [1:0]      s_npc;
  logic [15:0]     br_imm16;
  logic [25:0]     j_index;
  logic [31:0]     jr_target;
  logic [31:0]     imem_addr;
  logic [31:0]     imem_rdata;
  logic [31:0]     id_instr;
  logic [31:0]     id_pc4;
  logic            id_valid;
  logic            addr_err;
  logic [CntW-1:0] stall_cnt;
  logic [CntW-1:0] flush_cnt;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .CNT_W    (CntW)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .pc_write_i    (pc_write),
    .if_id_write_i (if_id_write),
    .s_npc_i       (s_npc),
    .br_imm16_i    (br_imm16),
    .j_index_i     (j_index),
    .jr_target_i   (jr_target),
    .imem_addr_o   (imem_addr),
    .imem_rdata_i  (imem_rdata),
    .id_instr_o    (id_instr),
    .id_pc4_o      (id_pc4),
    .id_valid_o    (id_valid),
    .addr_err_o    (addr_err),
    .stall_cnt_o   (stall_cnt),
    .flush_cnt_o   (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] imem(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  assign imem_rdata = imem(imem_addr);

  typedef struct {
    logic        pw;
    logic        iw;
    logic [1:0]  sel;
    logic [15:0] imm;
    logic [25:0] jidx;
    logic [31:0] jr;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic        err;
    logic [3:0]  stall;
    logic [3:0]  flush;
  } vec_t;

  function automatic vec_t mk(input logic pw, input logic iw, input logic [1:0] sel,
                              input logic [15:0] imm, input logic [25:0] jidx,
                              input logic [31:0] jr, input logic [31:0] pc,
                              input logic [31:0] instr, input logic [31:0] pc4,
                              input logic valid, input logic err,
                              input logic [3:0] stall, input logic [3:0] flush);
    vec_t v;
    v.pw = pw; v.iw = iw; v.sel = sel; v.imm = imm; v.jidx = jidx; v.jr = jr;
    v.pc = pc; v.instr = instr; v.pc4 = pc4; v.valid = valid; v.err = err;
    v.stall = stall; v.flush = flush;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                             input logic [31:0] pc4, input logic valid, input logic err,
                             input logic [3:0] stall, input logic [3:0] flush);
    check({tag, ".pc"},    imem_addr, pc);
    check({tag, ".instr"}, id_instr, instr);
    check({tag, ".pc4"},   id_pc4, pc4);
    check({tag, ".valid"}, {31'b0, id_valid}, {31'b0, valid});
    check({tag, ".err"},   {31'b0, addr_err}, {31'b0, err});
    check({tag, ".stall"}, {28'b0, stall_cnt}, {28'b0, stall});
    check({tag, ".flush"}, {28'b0, flush_cnt}, {28'b0, flush});
  endtask

  vec_t vecs[23];

  initial begin
    // Columns: pw iw sel imm jidx jr | pc instr pc4 valid err stall flush
    vecs[0]  = mk(0, 0, 2'b00, 16'h0, 26'h0, 32'h0, 32'h04, imem(32'h00), 32'h04, 1, 0, 0, 0);
    vecs[1]  = mk(0, 0, 2'b00, 16'h0, 26'h0, 32'h0, 32'h08, imem(32'h04), 32'h08, 1, 0, 0, 0);
    vecs[2]  = mk(0, 0, 2'b00, 16'h0, 26'h0, 32'h0, 32'h0C, imem(32'h08), 32'h0C, 1, 0, 0, 0);
    vecs[3]  = mk(0, 0, 2'b00, 16'h0, 26'h0, 32'h0, 32'h10, imem(32'h0C), 32'h10, 1, 0, 0, 0);
    vecs[4]  = mk(1, 1, 2'b00, 16'h0, 26'h0, 32'h0, 32'h10, imem(32'h0C), 32'h10, 1, 0, 1, 0);
    vecs[5]  = mk(1, 1, 2'b00, 16'h0, 26'h0, 32'h0, 32'h10, imem(32'h0C), 32'h10, 1, 0, 2, 0);
    vecs[6]  = mk(1, 1, 2'b00, 16'h0, 26'h0, 32'h0, 32'h10, imem(32'h0C), 32'h10, 1, 0, 3, 0);
    vecs[7]  = mk(0, 0, 2'b00, 16'h0, 26'h0, 32'h0, 32'h14, imem(32'h10), 32'h14, 1, 0, 3, 0);
    vecs[8]  = mk(0, 0, 2'b00, 16'h0, 26'h0, 32'h0, 32'h18, imem(32'h14), 32'h18, 1, 0, 3, 0);
    vecs[9]  = mk(0, 0, 2'b00, 16'h0, 26'h0, 32'h0, 32'h1C, imem(32'h18), 32'h1C, 1, 0, 3, 0);
    vecs[10] = mk(0, 0, 2'b00, 16'h0, 26'h0, 32'h0, 32'h20, imem(32'h1C), 32'h20, 1, 0, 3, 0);
    // Backward branch from ID_pc4=0x20 by -16 bytes.
    vecs[11] = mk(0, 0, 2'b01, 16'hFFFC, 26'h0, 32'h0, 32'h10, 32'h0, 32'h0, 0, 0, 3, 1);
    // Same select held but ID is a bubble: sequential fetch.
    vecs[12] = mk(0, 0, 2'b01, 16'hFFFC, 26'h0, 32'h0, 32'h14, imem(32'h10), 32'h14, 1, 0, 3, 1);
    // Branch pending under stall, then applied on release.
    vecs[13] = mk(1, 1, 2'b01, 16'h0004, 26'h0, 32'h0, 32'h14, imem(32'h10), 32'h14, 1, 0, 4, 1);
    vecs[14] = mk(1, 1, 2'b01, 16'h0004, 26'h0, 32'h0, 32'h14, imem(32'h10), 32'h14, 1, 0, 5, 1);
    vecs[15] = mk(0, 0, 2'b01, 16'h0004, 26'h0, 32'h0, 32'h24, 32'h0, 32'h0, 0, 0, 5, 2);
    vecs[16] = mk(0, 0, 2'b00, 16'h0, 26'h0, 32'h0, 32'h28, imem(32'h24), 32'h28, 1, 0, 5, 2);
    vecs[17] = mk(0, 0, 2'b10, 16'h0, 26'h40, 32'h0, 32'h100, 32'h0, 32'h0, 0, 0, 5, 3);
    vecs[18] = mk(0, 0, 2'b00, 16'h0, 26'h0, 32'h0, 32'h104, imem(32'h100), 32'h104, 1, 0, 5, 3);
    // Misaligned jr target sets the sticky error.
    vecs[19] = mk(0, 0, 2'b11, 16'h0, 26'h0, 32'h42, 32'h42, 32'h0, 32'h0, 0, 1, 5, 4);
    vecs[20] = mk(0, 0, 2'b00, 16'h0, 26'h0, 32'h0, 32'h46, imem(32'h42), 32'h46, 1, 1, 5, 4);
    vecs[21] = mk(0, 0, 2'b00, 16'h0, 26'h0, 32'h0, 32'h4A, imem(32'h46), 32'h4A, 1, 1, 5, 4);
    // Illegal hold-PC-only combination: IF/ID reloads the same fetch.
    vecs[22] = mk(1, 0, 2'b00, 16'h0, 26'h0, 32'h0, 32'h4A, imem(32'h4A), 32'h4E, 1, 1, 6, 4);

    rst_n = 1'b0; pc_write = 1'b0; if_id_write = 1'b0; s_npc = 2'b00;
    br_imm16 = '0; j_index = '0; jr_target = '0;
    #12;
    check_state("reset", 32'h0, 32'h0, 32'h0, 0, 0, 0, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 23; i++) begin
      pc_write = vecs[i].pw; if_id_write = vecs[i].iw; s_npc = vecs[i].sel;
      br_imm16 = vecs[i].imm; j_index = vecs[i].jidx; jr_target = vecs[i].jr;
      @(posedge clk);
      #1;
      check_state($sformatf("vec%0d", i), vecs[i].pc, vecs[i].instr, vecs[i].pc4,
                  vecs[i].valid, vecs[i].err, vecs[i].stall, vecs[i].flush);
    end

    // Valid instruction in ID with a jr pending; reset lands before the edge.
    pc_write = 1'b0; if_id_write = 1'b0; s_npc = 2'b11; jr_target = 32'h80;
    #3;
    rst_n = 1'b0;
    #1;
    check_state("async_rst", 32'h0, 32'h0, 32'h0, 0, 0, 0, 0);
    #3;
    rst_n = 1'b1;
    s_npc = 2'b00; jr_target = '0;
    @(posedge clk);
    #1;
    check_state("first_fetch", 32'h4, imem(32'h0), 32'h4, 1, 0, 0, 0);

    pc_write = 1'b1; if_id_write = 1'b1;
    for (int i = 0; i < 21; i++) begin
      @(posedge clk);
      #1;
    end
    check_state("stall_sat", 32'h4, imem(32'h0), 32'h4, 1, 0, 4'hF, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
